// File: rtl/rf_disp_pkg.sv
// Shared types and defaults for the register-file viewer/editor.
package rf_disp_pkg;

  typedef enum logic {S_CLEAR, S_IDLE} rf_state_t;

  localparam int DEF_DATA_W   = 4;
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_SCAN_DIV = 500;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/rf_scan_display_scan_timer.sv
// Auto-scan address generator: divides m_sec ticks and steps a wrapping address.
module scan_timer #(
  parameter int ADDR_W   = 3,
  parameter int SCAN_DIV = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_sec,
  input  logic              en,
  input  logic              hold,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] scan_addr
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] scan_cnt;

  // Hold wins over everything so a clear sweep freezes the scan exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      scan_addr <= '0;
    end else if (hold) begin
      scan_cnt  <= scan_cnt;
      scan_addr <= scan_addr;
    end else if (!en) begin
      scan_cnt  <= '0;
      scan_addr <= load_addr;
    end else if (m_sec) begin
      if (scan_cnt == CNT_LAST) begin
        scan_cnt  <= '0;
        scan_addr <= scan_addr + ADDR_W'(1);
      end else begin
        scan_cnt  <= scan_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rf_scan_display.sv
// Register-file viewer/editor: two async read ports, button-driven write, clear sweep, auto-scan.
module rf_scan_display
  import rf_disp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_sec,
  input  logic              m_write,
  input  logic              w_ena,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] rp_addr,
  input  logic [ADDR_W-1:0] rq_addr,
  input  logic              scan_en,
  input  logic              clr,
  output logic [DATA_W-1:0] rp_data,
  output logic [DATA_W-1:0] rq_data,
  output logic [ADDR_W-1:0] rq_addr_eff,
  output logic              busy,
  output logic              wr_done
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  rf_state_t         state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              m_write_q;
  logic              clr_q;
  logic              clr_edge;
  logic              wr_stb;
  logic [ADDR_W-1:0] scan_addr;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  assign busy     = (state == S_CLEAR);
  assign clr_edge = clr & ~clr_q & (state == S_IDLE);
  // A clear edge in the same cycle as a write strobe drops the write.
  assign wr_stb   = m_write & ~m_write_q & w_ena & (state == S_IDLE) & ~clr_edge;

  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (!rst) begin
      if (busy) begin
        mem_we = 1'b1;
        mem_wa = clr_ptr;
      end else if (wr_stb) begin
        mem_we = 1'b1;
        mem_wa = w_addr;
        mem_wd = w_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Edge registers reset to 1 so levels held through reset release are not seen as edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_CLEAR;
      clr_ptr   <= '0;
      m_write_q <= 1'b1;
      clr_q     <= 1'b1;
      wr_done   <= 1'b0;
    end else begin
      m_write_q <= m_write;
      clr_q     <= clr;
      wr_done   <= wr_stb;
      case (state)
        S_CLEAR: begin
          clr_ptr <= clr_ptr + ADDR_W'(1);
          if (clr_ptr == PTR_LAST) state <= S_IDLE;
        end
        S_IDLE: begin
          if (clr_edge) begin
            state   <= S_CLEAR;
            clr_ptr <= '0;
          end
        end
        default: begin
          state   <= S_CLEAR;
          clr_ptr <= '0;
        end
      endcase
    end
  end

  scan_timer #(
    .ADDR_W  (ADDR_W),
    .SCAN_DIV(SCAN_DIV)
  ) u_scan_timer (
    .clk      (clk),
    .rst      (rst),
    .m_sec    (m_sec),
    .en       (scan_en),
    .hold     (busy),
    .load_addr(rq_addr),
    .scan_addr(scan_addr)
  );

  assign rq_addr_eff = scan_en ? scan_addr : rq_addr;
  assign rp_data     = busy ? '0 : mem[rp_addr];
  assign rq_data     = busy ? '0 : mem[rq_addr_eff];

endmodule

// File: tb/tb_rf_scan_display.sv
// Directed bench for rf_scan_display: default-size instance plus an 8x16 instance.
module tb_rf_scan_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DATA_W=4, ADDR_W=3, SCAN_DIV=4
  logic       rst, m_sec, m_write, w_ena, scan_en, clr;
  logic [2:0] w_addr, rp_addr, rq_addr, rq_addr_eff;
  logic [3:0] w_data, rp_data, rq_data;
  logic       busy, wr_done;

  // Instance B: DATA_W=8, ADDR_W=4, SCAN_DIV=2
  logic       b_rst, b_m_sec, b_m_write, b_w_ena, b_scan_en, b_clr;
  logic [3:0] b_w_addr, b_rp_addr, b_rq_addr, b_rq_addr_eff;
  logic [7:0] b_w_data, b_rp_data, b_rq_data;
  logic       b_busy, b_wr_done;

  rf_scan_display #(.DATA_W(4), .ADDR_W(3), .SCAN_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .m_sec(m_sec), .m_write(m_write), .w_ena(w_ena),
    .w_addr(w_addr), .w_data(w_data), .rp_addr(rp_addr), .rq_addr(rq_addr),
    .scan_en(scan_en), .clr(clr), .rp_data(rp_data), .rq_data(rq_data),
    .rq_addr_eff(rq_addr_eff), .busy(busy), .wr_done(wr_done)
  );

  rf_scan_display #(.DATA_W(8), .ADDR_W(4), .SCAN_DIV(2)) dut_b (
    .clk(clk), .rst(b_rst), .m_sec(b_m_sec), .m_write(b_m_write), .w_ena(b_w_ena),
    .w_addr(b_w_addr), .w_data(b_w_data), .rp_addr(b_rp_addr), .rq_addr(b_rq_addr),
    .scan_en(b_scan_en), .clr(b_clr), .rp_data(b_rp_data), .rq_data(b_rq_data),
    .rq_addr_eff(b_rq_addr_eff), .busy(b_busy), .wr_done(b_wr_done)
  );

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt_a = 0;
  int wr_cnt_b = 0;
  logic [2:0] exp_q[$];

  always @(negedge clk) begin
    if (wr_done)   wr_cnt_a++;
    if (b_wr_done) wr_cnt_b++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts cycles with busy high starting from the current sample point.
  task automatic count_busy_a(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic press_a(input logic [2:0] a, input logic [3:0] d);
    w_addr  = a;
    w_data  = d;
    m_write = 1'b1;
    tick();
    m_write = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    int base;
    rst = 1'b1; m_sec = 0; m_write = 0; w_ena = 0; scan_en = 0; clr = 0;
    w_addr = 0; w_data = 0; rp_addr = 3'd5; rq_addr = 3'd2;
    b_rst = 1'b1; b_m_sec = 0; b_m_write = 0; b_w_ena = 0; b_scan_en = 0; b_clr = 0;
    b_w_addr = 0; b_w_data = 0; b_rp_addr = 0; b_rq_addr = 0;

    // Reset state
    tick(3);
    check("rst_busy", busy, 1);
    check("rst_rp_data", rp_data, 0);
    check("rst_rq_data", rq_data, 0);
    check("rst_wr_done", wr_done, 0);
    check("rst_eff_manual", rq_addr_eff, 3'd2);
    scan_en = 1'b1;
    #1;
    check("rst_eff_scan", rq_addr_eff, 3'd0);
    scan_en = 1'b0;
    tick();

    // Clear sweep after reset release
    rst = 1'b0;
    count_busy_a(n);
    check("rst_busy_len", n, 8);
    tick(3);
    check("idle_rp_data", rp_data, 0);
    check("idle_rq_data", rq_data, 0);
    check("idle_no_wr_done", wr_cnt_a, 0);

    // One write per press, old data in strobe cycle, new data next cycle
    w_ena = 1'b1; w_addr = 3'd3; w_data = 4'hA; rp_addr = 3'd3;
    base = wr_cnt_a;
    m_write = 1'b1;
    #1;
    check("wr_old_data", rp_data, 4'h0);
    tick();
    check("wr_done_pulse", wr_done, 1);
    check("wr_new_data", rp_data, 4'hA);
    tick(19);
    check("wr_done_low", wr_done, 0);
    m_write = 1'b0;
    tick(2);
    check("wr_once", wr_cnt_a - base, 1);

    // Write with w_ena low does nothing
    w_ena = 1'b0;
    base = wr_cnt_a;
    w_data = 4'h5;
    m_write = 1'b1; tick(3); m_write = 1'b0; tick(2);
    check("wena0_data", rp_data, 4'hA);
    check("wena0_no_done", wr_cnt_a - base, 0);

    // Button held across reset release
    w_ena = 1'b1; w_addr = 3'd1; w_data = 4'h7; m_write = 1'b1;
    rst = 1'b1; tick(2); rst = 1'b0;
    base = wr_cnt_a;
    count_busy_a(n);
    check("rst2_busy_len", n, 8);
    tick(3);
    rp_addr = 3'd1; #1;
    check("held_no_write", rp_data, 0);
    check("held_no_done", wr_cnt_a - base, 0);
    rp_addr = 3'd3; #1;
    check("rst_clears_array", rp_data, 0);
    m_write = 1'b0;
    tick();

    // Press during the busy sweep is dropped
    rst = 1'b1; tick(2); rst = 1'b0;
    tick(2);
    check("busy_mid", busy, 1);
    w_addr = 3'd1; m_write = 1'b1;
    count_busy_a(n);
    tick(3);
    m_write = 1'b0;
    rp_addr = 3'd1; #1;
    check("busy_press_dropped", rp_data, 0);
    check("busy_press_no_done", wr_cnt_a - base, 0);
    tick();

    // Auto-scan from address 6, SCAN_DIV = 4
    rq_addr = 3'd6; tick(2);
    scan_en = 1'b1; #1;
    check("scan_start", rq_addr_eff, 3'd6);
    exp_q.push_back(3'd7); exp_q.push_back(3'd0); exp_q.push_back(3'd1);
    for (int p = 1; p <= 12; p++) begin
      m_sec = 1'b1; tick(); m_sec = 1'b0;
      if (p == 3) check("scan_pre_step", rq_addr_eff, 3'd6);
      if (p % 4 == 0) check("scan_step", rq_addr_eff, exp_q.pop_front());
      tick(9);
    end
    rq_addr = 3'd2; scan_en = 1'b0; #1;
    check("scan_off", rq_addr_eff, 3'd2);
    tick();

    // Fill, then clear sweep on clr edge
    w_ena = 1'b1;
    for (int a = 0; a < 8; a++) press_a(3'(a), 4'(a + 8));
    for (int a = 0; a < 8; a++) begin
      rp_addr = 3'(a); #1;
      check("fill_read", rp_data, a + 8);
    end
    rp_addr = 3'd5; rq_addr = 3'd6;
    clr = 1'b1;
    tick();
    n = 0;
    while (busy && n < 40) begin
      if (rp_data !== 4'h0 || rq_data !== 4'h0) check("clr_busy_out", {rp_data, rq_data}, 0);
      n++;
      tick();
    end
    check("clr_busy_len", n, 8);
    tick(3);
    check("clr_no_retrigger", busy, 0);
    clr = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rp_addr = 3'(a); #1;
      check("clr_read", rp_data, 0);
    end
    tick();

    // clr edge coincident with a write strobe: clear wins
    base = wr_cnt_a;
    w_addr = 3'd4; w_data = 4'h9;
    m_write = 1'b1; clr = 1'b1;
    tick();
    check("coinc_busy", busy, 1);
    count_busy_a(n);
    tick(2);
    m_write = 1'b0; clr = 1'b0;
    rp_addr = 3'd4; #1;
    check("coinc_write_lost", rp_data, 0);
    check("coinc_no_done", wr_cnt_a - base, 0);

    // Wide instance: 16-entry clear and 8-bit write
    b_rst = 1'b0;
    n = 0;
    while (b_busy && n < 60) begin
      n++;
      tick();
    end
    check("b_busy_len", n, 16);
    b_w_ena = 1'b1; b_w_addr = 4'd15; b_w_data = 8'hC3;
    b_rp_addr = 4'd15; b_rq_addr = 4'd15;
    b_m_write = 1'b1; tick(); b_m_write = 1'b0;
    check("b_wr_done", b_wr_done, 1);
    check("b_rp_data", b_rp_data, 8'hC3);
    check("b_rq_data", b_rq_data, 8'hC3);
    b_clr = 1'b1; tick();
    n = 0;
    while (b_busy && n < 60) begin
      n++;
      tick();
    end
    check("b_clr_len", n, 16);
    check("b_clr_data", b_rp_data, 0);
    check("b_wr_count", wr_cnt_b, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
